// File: rtl/stump_mem_responder.sv
// Memory/IO responder for the STUMP processor: on-chip RAM, an LED register, a
// free-running cycle counter and switch inputs behind a request/ready handshake.
module stump_mem_responder #(
  parameter int WAIT_STATES = 1,
  parameter int RAM_ABITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic [15:0] wdata,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [7:0]  switches,
  output logic [15:0] rdata,
  output logic        mem_ready,
  output logic [7:0]  leds,
  output logic        bus_err
);

  // state   | meaning
  // IDLE    | waiting for mem_ren/mem_wen; request latched when seen
  // WAIT    | counting down the configured wait states
  // RESPOND | access completed at entry; mem_ready high for this cycle
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  localparam logic [3:0]  WS_LOAD   = 4'(WAIT_STATES);
  localparam logic [16:0] RAM_WORDS = 17'(2 ** RAM_ABITS);
  localparam logic [15:0] ADDR_LED  = 16'hFF00;
  localparam logic [15:0] ADDR_CYC  = 16'hFF01;
  localparam logic [15:0] ADDR_SW   = 16'hFF02;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [15:0] cyc_q, cyc_d;
  logic        bus_err_q, bus_err_d;

  logic [15:0] ram [2 ** RAM_ABITS];

  logic        commit;
  logic [15:0] op_addr;
  logic [15:0] op_wdata;
  logic        op_ren;
  logic        op_wen;
  logic        is_ram;
  logic        ram_we;
  logic [RAM_ABITS-1:0] ram_idx;

  // With zero wait states the access completes on the sampling edge itself,
  // so the live request is used instead of the (not yet loaded) latched copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      op_addr  = address;
      op_wdata = wdata;
      op_ren   = mem_ren;
      op_wen   = mem_wen;
    end else begin
      op_addr  = addr_q;
      op_wdata = wdata_q;
      op_ren   = ren_q;
      op_wen   = wen_q;
    end
  end

  assign is_ram  = ({1'b0, op_addr} < RAM_WORDS);
  assign ram_idx = op_addr[RAM_ABITS-1:0];

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ren_d      = ren_q;
    wen_d      = wen_q;
    commit     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_ren || mem_wen) begin
          addr_d     = address;
          wdata_d    = wdata;
          ren_d      = mem_ren;
          wen_d      = mem_wen;
          wait_cnt_d = WS_LOAD;
          if (WS_LOAD == 4'd0) begin
            state_d = S_RESPOND;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q <= 4'd1) begin
          state_d = S_RESPOND;
          commit  = 1'b1;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Access decode: evaluated only on the edge that enters RESPOND.
  always_comb begin
    rdata_d   = rdata_q;
    led_d     = led_q;
    bus_err_d = bus_err_q;
    cyc_d     = cyc_q + 16'd1;
    ram_we    = 1'b0;

    if (commit) begin
      if (op_ren && op_wen) begin
        rdata_d   = 16'h0000;
        bus_err_d = 1'b1;
      end else if (op_wen) begin
        if (is_ram) begin
          ram_we = !rst;
        end else if (op_addr == ADDR_LED) begin
          led_d = op_wdata;
        end else if (op_addr != ADDR_CYC && op_addr != ADDR_SW) begin
          bus_err_d = 1'b1;
        end
      end else begin
        if (is_ram) begin
          rdata_d = ram[ram_idx];
        end else if (op_addr == ADDR_LED) begin
          rdata_d = led_q;
        end else if (op_addr == ADDR_CYC) begin
          rdata_d = cyc_q;
        end else if (op_addr == ADDR_SW) begin
          rdata_d = {8'h00, switches};
        end else begin
          rdata_d   = 16'h0000;
          bus_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      rdata_q    <= 16'h0000;
      led_q      <= 16'h0000;
      cyc_q      <= 16'h0000;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      rdata_q    <= rdata_d;
      led_q      <= led_d;
      cyc_q      <= cyc_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // RAM contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= op_wdata;
    end
  end

  assign rdata     = rdata_q;
  assign mem_ready = (state_q == S_RESPOND);
  assign leds      = led_q[7:0];
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_stump_mem_responder.sv
// Bench for stump_mem_responder: three instances (0, 1 and 3 wait states)
// checked every cycle against a transaction-level model plus literal checks.
module tb_stump_mem_responder;

  localparam int NI = 3;
  localparam int WS [NI] = '{1, 0, 3};

  logic        clk;
  logic        rst;
  logic [7:0]  switches;
  logic [15:0] address [NI];
  logic [15:0] wdata   [NI];
  logic        mem_ren [NI];
  logic        mem_wen [NI];
  logic [15:0] rdata_o [NI];
  logic        ready_o [NI];
  logic [7:0]  leds_o  [NI];
  logic        err_o   [NI];

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  stump_mem_responder #(.WAIT_STATES(1), .RAM_ABITS(8)) u_ws1 (
    .clk(clk), .rst(rst), .address(address[0]), .wdata(wdata[0]),
    .mem_ren(mem_ren[0]), .mem_wen(mem_wen[0]), .switches(switches),
    .rdata(rdata_o[0]), .mem_ready(ready_o[0]), .leds(leds_o[0]), .bus_err(err_o[0]));

  stump_mem_responder #(.WAIT_STATES(0), .RAM_ABITS(8)) u_ws0 (
    .clk(clk), .rst(rst), .address(address[1]), .wdata(wdata[1]),
    .mem_ren(mem_ren[1]), .mem_wen(mem_wen[1]), .switches(switches),
    .rdata(rdata_o[1]), .mem_ready(ready_o[1]), .leds(leds_o[1]), .bus_err(err_o[1]));

  stump_mem_responder #(.WAIT_STATES(3), .RAM_ABITS(8)) u_ws3 (
    .clk(clk), .rst(rst), .address(address[2]), .wdata(wdata[2]),
    .mem_ren(mem_ren[2]), .mem_wen(mem_wen[2]), .switches(switches),
    .rdata(rdata_o[2]), .mem_ready(ready_o[2]), .leds(leds_o[2]), .bus_err(err_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- transaction-level model ----------------
  bit          model_on = 0;
  bit          busy    [NI];
  int          resp_e  [NI];
  logic [15:0] l_addr  [NI];
  logic [15:0] l_wd    [NI];
  bit          l_ren   [NI];
  bit          l_wen   [NI];
  logic [15:0] m_rdata [NI];
  bit          m_known [NI];
  bit          m_ready [NI];
  logic [15:0] m_led   [NI];
  bit          m_err   [NI];
  logic [15:0] m_mem   [NI][256];
  bit          m_memv  [NI][256];
  logic [15:0] m_cyc;

  task automatic model_op(input int i);
    logic [15:0] a;
    a = l_addr[i];
    if (l_ren[i] && l_wen[i]) begin
      m_err[i] = 1; m_rdata[i] = 16'h0000; m_known[i] = 1;
    end else if (l_wen[i]) begin
      if (a < 16'd256) begin
        m_mem[i][a[7:0]] = l_wd[i]; m_memv[i][a[7:0]] = 1;
      end else if (a == 16'hFF00) m_led[i] = l_wd[i];
      else if (a != 16'hFF01 && a != 16'hFF02) m_err[i] = 1;
    end else begin
      m_known[i] = 1;
      if (a < 16'd256) begin
        m_rdata[i] = m_mem[i][a[7:0]]; m_known[i] = m_memv[i][a[7:0]];
      end else if (a == 16'hFF00) m_rdata[i] = m_led[i];
      else if (a == 16'hFF01) m_rdata[i] = m_cyc;
      else if (a == 16'hFF02) m_rdata[i] = {8'h00, switches};
      else begin
        m_rdata[i] = 16'h0000; m_err[i] = 1;
      end
    end
  endtask

  // A request accepted at edge E completes at edge E+WS; the instance can
  // accept again two edges after completion.
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (rst) begin
      model_on = 1;
      m_cyc = 16'h0000;
      for (int i = 0; i < NI; i++) begin
        busy[i] = 0; m_ready[i] = 0; m_rdata[i] = 16'h0000; m_known[i] = 1;
        m_led[i] = 16'h0000; m_err[i] = 0;
      end
    end else if (model_on) begin
      for (int i = 0; i < NI; i++) begin
        m_ready[i] = 0;
        if (busy[i] && edge_n == resp_e[i] + 1) begin
          busy[i] = 0;
        end else if (!busy[i] && (mem_ren[i] || mem_wen[i])) begin
          busy[i] = 1; resp_e[i] = edge_n + WS[i];
          l_addr[i] = address[i]; l_wd[i] = wdata[i];
          l_ren[i] = mem_ren[i]; l_wen[i] = mem_wen[i];
        end
        if (busy[i] && edge_n == resp_e[i]) begin
          model_op(i);
          m_ready[i] = 1;
        end
      end
      m_cyc = m_cyc + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (ready_o[i] !== m_ready[i]) begin
          n_fail++;
          $display("FAIL model_ready[%0d] t=%0t got %b expected %b", i, $time, ready_o[i], m_ready[i]);
        end
        n_checks++;
        if (leds_o[i] !== m_led[i][7:0]) begin
          n_fail++;
          $display("FAIL model_leds[%0d] t=%0t got %h expected %h", i, $time, leds_o[i], m_led[i][7:0]);
        end
        n_checks++;
        if (err_o[i] !== m_err[i]) begin
          n_fail++;
          $display("FAIL model_bus_err[%0d] t=%0t got %b expected %b", i, $time, err_o[i], m_err[i]);
        end
        if (m_known[i]) begin
          n_checks++;
          if (rdata_o[i] !== m_rdata[i]) begin
            n_fail++;
            $display("FAIL model_rdata[%0d] t=%0t got %h expected %h", i, $time, rdata_o[i], m_rdata[i]);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Latency counts cycles inclusively from the cycle the request is driven.
  task automatic access(input int i, input bit ren, input bit wen, input logic [15:0] a,
                        input logic [15:0] wd, output logic [15:0] rd, output int e_resp);
    int  lat;
    bit  got;
    @(negedge clk); #1;
    address[i] = a; wdata[i] = wd; mem_ren[i] = ren; mem_wen[i] = wen;
    lat = 1; got = 0; rd = 16'hxxxx; e_resp = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (ready_o[i] === 1'b1) begin
        got = 1; rd = rdata_o[i]; e_resp = edge_n;
      end
    end
    #1;
    mem_ren[i] = 0; mem_wen[i] = 0;
    n_checks++;
    if (!got || lat != WS[i] + 2) begin
      n_fail++;
      $display("FAIL latency[%0d] addr=%h got %0d cycles (seen=%0b) expected %0d", i, a, lat, got, WS[i] + 2);
    end
  endtask

  logic [15:0] rd, v1, v2;
  int          e1, e2, bound;
  bit          saw_ready;

  initial begin
    rst = 1; switches = 8'h00;
    for (int i = 0; i < NI; i++) begin
      address[i] = 0; wdata[i] = 0; mem_ren[i] = 0; mem_wen[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check16("reset_rdata", rdata_o[0], 16'h0000);
    check16("reset_leds", {8'h00, leds_o[1]}, 16'h0000);
    check16("reset_err_ready", {14'd0, err_o[2], ready_o[2]}, 16'h0000);
    #1 rst = 0;

    // 1 wait state: RAM write then read back
    access(0, 0, 1, 16'h0010, 16'h1234, rd, e1);
    access(0, 1, 0, 16'h0010, 16'h0000, rd, e1);
    check16("ws1_ram_read", rd, 16'h1234);

    // 0 wait states: LED register and switches
    access(1, 0, 1, 16'hFF00, 16'h00A5, rd, e1);
    check16("ws0_leds", {8'h00, leds_o[1]}, 16'h00A5);
    access(1, 1, 0, 16'hFF00, 16'h0000, rd, e1);
    check16("ws0_led_read", rd, 16'h00A5);
    switches = 8'h3C;
    access(1, 1, 0, 16'hFF02, 16'h0000, rd, e1);
    check16("ws0_switch_read", rd, 16'h003C);
    access(1, 0, 1, 16'hFF02, 16'hFFFF, rd, e1);
    access(1, 0, 1, 16'hFF01, 16'hFFFF, rd, e1);
    check16("ro_write_no_err", {15'd0, err_o[1]}, 16'h0000);

    // simultaneous read+write
    access(0, 0, 1, 16'h0020, 16'h5555, rd, e1);
    access(0, 1, 1, 16'h0020, 16'hAAAA, rd, e1);
    check16("conflict_rdata", rd, 16'h0000);
    check16("conflict_err", {15'd0, err_o[0]}, 16'h0001);
    access(0, 1, 0, 16'h0020, 16'h0000, rd, e1);
    check16("conflict_no_write", rd, 16'h5555);

    // unmapped address, sticky error
    access(1, 1, 0, 16'h8000, 16'h0000, rd, e1);
    check16("unmapped_rdata", rd, 16'h0000);
    check16("unmapped_err", {15'd0, err_o[1]}, 16'h0001);
    access(1, 1, 0, 16'hFF00, 16'h0000, rd, e1);
    check16("err_sticky", {15'd0, err_o[1]}, 16'h0001);

    // 3 wait states: reset during WAIT abandons the write
    access(2, 0, 1, 16'h0005, 16'h1111, rd, e1);
    @(negedge clk); #1;
    address[2] = 16'h0005; wdata[2] = 16'hBEEF; mem_wen[2] = 1;
    repeat (2) @(negedge clk);
    #1 rst = 1; mem_wen[2] = 0;
    @(negedge clk); #1 rst = 0;
    saw_ready = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready_o[2] === 1'b1) saw_ready = 1;
    end
    check16("abandon_no_ready", {15'd0, saw_ready}, 16'h0000);
    check16("reset_clears_err", {15'd0, err_o[1]}, 16'h0000);
    access(2, 1, 0, 16'h0005, 16'h0000, rd, e1);
    check16("abandon_no_write", rd, 16'h1111);

    // cycle counter spacing
    access(1, 1, 0, 16'hFF01, 16'h0000, v1, e1);
    repeat (7) @(negedge clk);
    access(1, 1, 0, 16'hFF01, 16'h0000, v2, e2);
    check16("cyc_delta", v2 - v1, 16'(e2 - e1));

    // cycle counter across wrap
    bound = 0;
    while (m_cyc < 16'd65525 && bound < 70000) begin
      @(negedge clk);
      bound++;
    end
    check16("wrap_wait_bound", {15'd0, (bound >= 70000)}, 16'h0000);
    access(1, 1, 0, 16'hFF01, 16'h0000, v1, e1);
    repeat (15) @(negedge clk);
    access(1, 1, 0, 16'hFF01, 16'h0000, v2, e2);
    check16("wrap_delta", v2 - v1, 16'(e2 - e1));
    check16("wrap_seen", {15'd0, (v2 < v1)}, 16'h0001);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
